// File: rtl/pong_game_controller_pkg.sv
// Shared field geometry, state encoding and ball helpers for the Pong game-state sequencer.
package pong_game_controller_pkg;

  localparam int unsigned LOC_W   = 10;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned STEP_W  = 11;

  localparam int unsigned FIELD_X_BEGIN    = 20;
  localparam int unsigned FIELD_X_END      = 619;
  localparam int unsigned FIELD_Y_BEGIN    = 20;
  localparam int unsigned FIELD_Y_END      = 459;
  localparam int unsigned BALL_RADIUS      = 4;
  localparam int unsigned PADDLE_RADIUS    = 32;
  localparam int unsigned PADDLE_THICKNESS = 8;

  localparam int unsigned CENTER_X   = (FIELD_X_BEGIN + FIELD_X_END) / 2;
  localparam int unsigned CENTER_Y   = (FIELD_Y_BEGIN + FIELD_Y_END) / 2;
  localparam int unsigned PADDLE_MIN = FIELD_Y_BEGIN + PADDLE_RADIUS;
  localparam int unsigned PADDLE_MAX = FIELD_Y_END - PADDLE_RADIUS;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SERVE     = 2'd1,
    ST_PLAY      = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  // Signed step coordinate: one extra bit so a ball step below 0 cannot wrap.
  typedef logic signed [STEP_W-1:0] coord_t;

  typedef struct packed {
    logic [LOC_W-1:0] x;
    logic [LOC_W-1:0] y;
    logic             dx_neg;
    logic             dy_neg;
  } ball_t;

  // True when the ball centre row is within reach of the paddle face.
  function automatic logic paddle_reach(input coord_t ny, input logic [LOC_W-1:0] pad);
    coord_t diff;
    diff = ny - coord_t'({1'b0, pad});
    if (diff < 0) diff = -diff;
    return diff <= coord_t'(PADDLE_RADIUS + BALL_RADIUS);
  endfunction

endpackage

// File: rtl/pong_game_controller_paddle.sv
// Per-paddle vertical motion with clamping, advanced once per frame while enabled.
module pong_paddle_mover
  import pong_game_controller_pkg::*;
#(
  parameter int unsigned PADDLE_SPEED = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             enable,
  input  logic             center,
  input  logic             up,
  input  logic             down,
  output logic [LOC_W-1:0] loc
);

  localparam logic [LOC_W-1:0] STEP = LOC_W'(PADDLE_SPEED);
  localparam logic [LOC_W-1:0] LO   = LOC_W'(PADDLE_MIN);
  localparam logic [LOC_W-1:0] HI   = LOC_W'(PADDLE_MAX);
  localparam logic [LOC_W-1:0] MID  = LOC_W'(CENTER_Y);

  logic [LOC_W-1:0] r_loc;
  logic [LOC_W-1:0] w_loc_next;

  // Opposing buttons cancel; each direction saturates at the field limit.
  always_comb begin
    w_loc_next = r_loc;
    if (up && !down) begin
      w_loc_next = (r_loc < LO + STEP) ? LO : r_loc - STEP;
    end else if (down && !up) begin
      w_loc_next = (r_loc > HI - STEP) ? HI : r_loc + STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loc <= MID;
    end else if (center) begin
      r_loc <= MID;
    end else if (frame_tick && enable) begin
      r_loc <= w_loc_next;
    end
  end

  assign loc = r_loc;

endmodule

// File: rtl/pong_game_controller.sv
// Pong game-state sequencer: ball motion, bounces, scoring and serve/game-over flow, once per frame.
module pong_game_controller
  import pong_game_controller_pkg::*;
#(
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               left_up,
  input  logic               left_down,
  input  logic               right_up,
  input  logic               right_down,
  output logic [LOC_W-1:0]   ball_loc_x,
  output logic [LOC_W-1:0]   ball_loc_y,
  output logic [LOC_W-1:0]   left_paddle_loc,
  output logic [LOC_W-1:0]   right_paddle_loc,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic               game_over
);

  localparam int unsigned SERVE_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  localparam coord_t STEP    = coord_t'(BALL_SPEED);
  localparam coord_t Y_LO    = coord_t'(FIELD_Y_BEGIN + BALL_RADIUS);
  localparam coord_t Y_HI    = coord_t'(FIELD_Y_END - BALL_RADIUS);
  localparam coord_t X_LPAD  = coord_t'(FIELD_X_BEGIN + PADDLE_THICKNESS + BALL_RADIUS);
  localparam coord_t X_RPAD  = coord_t'(FIELD_X_END - PADDLE_THICKNESS - BALL_RADIUS);
  localparam coord_t X_LGOAL = coord_t'(FIELD_X_BEGIN + BALL_RADIUS);
  localparam coord_t X_RGOAL = coord_t'(FIELD_X_END - BALL_RADIUS);

  localparam ball_t BALL_HOME = '{x: LOC_W'(CENTER_X), y: LOC_W'(CENTER_Y), dx_neg: 1'b0, dy_neg: 1'b0};

  state_e             r_state, w_state_next;
  ball_t              r_ball;
  logic [SCORE_W-1:0] r_left_score, r_right_score;
  logic [SERVE_W-1:0] r_serve_cnt;

  logic [LOC_W-1:0]   w_left_loc, w_right_loc;
  logic               w_paddle_en, w_clear_scores, w_serve_tick, w_ball_step, w_restore, w_serve_enter;

  coord_t             w_x, w_y, w_nx_raw, w_ny_raw, w_nx, w_ny;
  logic               w_dx_neg, w_dy_neg, w_hit_l, w_hit_r, w_pt_left, w_pt_right, w_goal, w_win;
  logic [SCORE_W-1:0] w_left_inc, w_right_inc;

  // Candidate ball step; paddle tests see the paddle registers before this frame's move.
  always_comb begin
    w_x      = coord_t'({1'b0, r_ball.x});
    w_y      = coord_t'({1'b0, r_ball.y});
    w_nx_raw = r_ball.dx_neg ? w_x - STEP : w_x + STEP;
    w_ny_raw = r_ball.dy_neg ? w_y - STEP : w_y + STEP;
    w_ny     = w_ny_raw;
    w_dy_neg = r_ball.dy_neg;
    if (w_ny_raw <= Y_LO) begin
      w_ny     = Y_LO;
      w_dy_neg = 1'b0;
    end else if (w_ny_raw >= Y_HI) begin
      w_ny     = Y_HI;
      w_dy_neg = 1'b1;
    end
    w_hit_l  = r_ball.dx_neg && (w_nx_raw <= X_LPAD) && paddle_reach(w_ny, w_left_loc);
    w_hit_r  = !r_ball.dx_neg && (w_nx_raw >= X_RPAD) && paddle_reach(w_ny, w_right_loc);
    w_nx     = w_nx_raw;
    w_dx_neg = r_ball.dx_neg;
    if (w_hit_l) begin
      w_nx     = X_LPAD;
      w_dx_neg = 1'b0;
    end else if (w_hit_r) begin
      w_nx     = X_RPAD;
      w_dx_neg = 1'b1;
    end
    w_pt_right = !w_hit_l && !w_hit_r && (w_nx_raw <= X_LGOAL);
    w_pt_left  = !w_hit_l && !w_hit_r && !w_pt_right && (w_nx_raw >= X_RGOAL);
    if (w_pt_right) w_dx_neg = 1'b1;
    if (w_pt_left)  w_dx_neg = 1'b0;
    w_goal      = w_pt_right || w_pt_left;
    w_left_inc  = (r_left_score  >= WIN) ? r_left_score  : r_left_score  + SCORE_W'(1);
    w_right_inc = (r_right_score >= WIN) ? r_right_score : r_right_score + SCORE_W'(1);
    w_win       = (w_pt_right && (w_right_inc == WIN)) || (w_pt_left && (w_left_inc == WIN));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_state_next = ST_SERVE;
      ST_SERVE:     if (frame_tick && (r_serve_cnt == SERVE_LAST)) w_state_next = ST_PLAY;
      ST_PLAY:      if (frame_tick && w_goal) w_state_next = w_win ? ST_GAME_OVER : ST_SERVE;
      ST_GAME_OVER: if (frame_tick && start) w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_paddle_en    = 1'b0;
    w_clear_scores = 1'b0;
    w_serve_tick   = 1'b0;
    w_ball_step    = 1'b0;
    w_restore      = 1'b0;
    case (r_state)
      ST_IDLE:      w_clear_scores = start;
      ST_SERVE: begin
        w_paddle_en  = 1'b1;
        w_serve_tick = frame_tick;
      end
      ST_PLAY: begin
        w_paddle_en = 1'b1;
        w_ball_step = frame_tick;
      end
      ST_GAME_OVER: w_restore = frame_tick && start;
      default:      w_paddle_en = 1'b0;
    endcase
    w_serve_enter = (w_state_next == ST_SERVE) && (r_state != ST_SERVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_serve_cnt <= '0;
    end else if (w_serve_enter) begin
      r_serve_cnt <= '0;
    end else if (w_serve_tick && (r_serve_cnt != SERVE_LAST)) begin
      r_serve_cnt <= r_serve_cnt + SERVE_W'(1);
    end
  end

  // A goal that does not end the game puts the ball back at centre for the next serve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ball <= BALL_HOME;
    end else if (w_restore) begin
      r_ball <= BALL_HOME;
    end else if (w_ball_step) begin
      r_ball.dx_neg <= w_dx_neg;
      r_ball.dy_neg <= w_dy_neg;
      if (w_goal && !w_win) begin
        r_ball.x <= BALL_HOME.x;
        r_ball.y <= BALL_HOME.y;
      end else begin
        r_ball.x <= LOC_W'(w_nx);
        r_ball.y <= LOC_W'(w_ny);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left_score  <= '0;
      r_right_score <= '0;
    end else if (w_clear_scores || w_restore) begin
      r_left_score  <= '0;
      r_right_score <= '0;
    end else if (w_ball_step) begin
      if (w_pt_left)  r_left_score  <= w_left_inc;
      if (w_pt_right) r_right_score <= w_right_inc;
    end
  end

  pong_paddle_mover #(.PADDLE_SPEED(PADDLE_SPEED)) u_left_paddle (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (w_paddle_en),
    .center     (w_restore),
    .up         (left_up),
    .down       (left_down),
    .loc        (w_left_loc)
  );

  pong_paddle_mover #(.PADDLE_SPEED(PADDLE_SPEED)) u_right_paddle (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (w_paddle_en),
    .center     (w_restore),
    .up         (right_up),
    .down       (right_down),
    .loc        (w_right_loc)
  );

  assign ball_loc_x       = r_ball.x;
  assign ball_loc_y       = r_ball.y;
  assign left_paddle_loc  = w_left_loc;
  assign right_paddle_loc = w_right_loc;
  assign left_score       = r_left_score;
  assign right_score      = r_right_score;
  assign game_over        = (r_state == ST_GAME_OVER);

endmodule
